// File: rtl/issueq_freelist_alloc.sv
// Circular free list of issue-queue slot indices: hands up to four free slots
// to dispatch per cycle and takes back up to four freed slots per cycle.
module issueq_freelist_alloc #(
  parameter int SIZE_ISSUEQ     = 64,
  parameter int SIZE_ISSUEQ_LOG = 6,
  parameter int DISPATCH_WIDTH  = 4
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       dispatchReady_i,
  input  logic [2:0]                 dispatchCount_i,
  input  logic                       ctrlMispredict_i,
  input  logic                       freedValid0_i,
  input  logic                       freedValid1_i,
  input  logic                       freedValid2_i,
  input  logic                       freedValid3_i,
  input  logic [SIZE_ISSUEQ_LOG-1:0] freedEntry0_i,
  input  logic [SIZE_ISSUEQ_LOG-1:0] freedEntry1_i,
  input  logic [SIZE_ISSUEQ_LOG-1:0] freedEntry2_i,
  input  logic [SIZE_ISSUEQ_LOG-1:0] freedEntry3_i,
  output logic [SIZE_ISSUEQ_LOG-1:0] allocEntry0_o,
  output logic [SIZE_ISSUEQ_LOG-1:0] allocEntry1_o,
  output logic [SIZE_ISSUEQ_LOG-1:0] allocEntry2_o,
  output logic [SIZE_ISSUEQ_LOG-1:0] allocEntry3_o,
  output logic                       allocGrant_o,
  output logic                       iqStall_o,
  output logic [SIZE_ISSUEQ_LOG:0]   freeCount_o,
  output logic                       freeListError_o
);
  localparam int W     = SIZE_ISSUEQ_LOG;
  localparam int CNT_W = SIZE_ISSUEQ_LOG + 1;

  logic [W-1:0]     list_q [SIZE_ISSUEQ];
  logic [W-1:0]     head_q, head_d;
  logic [W-1:0]     tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             error_q, error_d;

  logic [DISPATCH_WIDTH-1:0] freed_valid;
  logic [W-1:0]              freed_entry [DISPATCH_WIDTH];
  logic [W-1:0]              rd_idx [DISPATCH_WIDTH];
  logic [W-1:0]              wr_idx [DISPATCH_WIDTH];
  logic [2:0]                wr_off [DISPATCH_WIDTH];
  logic [2:0]                nfree;
  logic                      req, illegal, enough, grant, stall, overflow;
  logic [CNT_W-1:0]          alloc_num;

  assign freed_valid    = {freedValid3_i, freedValid2_i, freedValid1_i, freedValid0_i};
  assign freed_entry[0] = freedEntry0_i;
  assign freed_entry[1] = freedEntry1_i;
  assign freed_entry[2] = freedEntry2_i;
  assign freed_entry[3] = freedEntry3_i;

  // Request handshake: dispatchReady_i & ~ctrlMispredict_i is the valid; the
  // grant is combinational in the same cycle and all-or-nothing, judged on the
  // registered count only, so same-cycle frees never help a request.
  assign req     = dispatchReady_i & ~ctrlMispredict_i;
  assign illegal = dispatchCount_i > 3'd4;
  assign enough  = count_q >= CNT_W'(dispatchCount_i);
  assign grant   = req & ~illegal & enough;
  assign stall   = req & (illegal | ~enough);

  always_comb begin
    nfree = '0;
    for (int k = 0; k < DISPATCH_WIDTH; k++) begin
      rd_idx[k] = head_q + W'(k);
      wr_off[k] = nfree;
      wr_idx[k] = tail_q + W'(nfree);
      nfree     = nfree + {2'b00, freed_valid[k]};
    end
  end

  // A free that would push the count past the list depth is dropped whole.
  assign overflow  = ({1'b0, count_q} + (CNT_W+1)'(nfree)) > (CNT_W+1)'(SIZE_ISSUEQ);
  assign alloc_num = grant ? CNT_W'(dispatchCount_i) : '0;

  always_comb begin
    head_d  = grant ? head_q + W'(dispatchCount_i) : head_q;
    tail_d  = overflow ? tail_q : tail_q + W'(nfree);
    count_d = count_q - alloc_num + (overflow ? '0 : CNT_W'(nfree));
    error_d = error_q | overflow | (req & illegal);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SIZE_ISSUEQ; i++) list_q[i] <= W'(i);
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= CNT_W'(SIZE_ISSUEQ);
      error_q <= 1'b0;
    end else begin
      for (int k = 0; k < DISPATCH_WIDTH; k++) begin
        if (freed_valid[k] && !overflow) list_q[wr_idx[k]] <= freed_entry[k];
      end
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      error_q <= error_d;
    end
  end

  assign allocEntry0_o   = list_q[rd_idx[0]];
  assign allocEntry1_o   = list_q[rd_idx[1]];
  assign allocEntry2_o   = list_q[rd_idx[2]];
  assign allocEntry3_o   = list_q[rd_idx[3]];
  assign allocGrant_o    = grant;
  assign iqStall_o       = stall;
  assign freeCount_o     = count_q;
  assign freeListError_o = error_q;
endmodule

// File: doc/issueq_freelist_alloc.md
Name: issueq_freelist_alloc

Overview:
- Circular free list of issue-queue entry indices.
- Allocates up to 4 entries per cycle to dispatch and accepts up to 4 freed entries per cycle from the issue-queue freeing logic.
- Sits between dispatch and the issue queue. It is the sole arbiter of which IQ slots new instructions occupy.
- Raises a stall when dispatch asks for more entries than the list holds.

Parameters:
- SIZE_ISSUEQ, 64, number of issue-queue entries, which is also the free-list depth.
- SIZE_ISSUEQ_LOG, 6, index width. Also the head/tail pointer width.
- DISPATCH_WIDTH, 4, allocate and free ports per cycle. Fixed at 4.

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- dispatchReady_i  in  1  dispatch bundle valid this cycle.
- dispatchCount_i  in  3  entries requested, 0..4. Values 5..7 are illegal.
- ctrlMispredict_i  in  1  mispredict this cycle; suppresses allocation.
- freedValid0_i..freedValid3_i  in  1 each  freed-entry valid.
- freedEntry0_i..freedEntry3_i  in  6 each  freed IQ index.
- allocEntry0_o..allocEntry3_o  out  6 each  next 4 free indices, in list order from head.
- allocGrant_o  out  1  request granted this cycle.
- iqStall_o  out  1  request cannot be satisfied.
- freeCount_o  out  7  free entries held, 0..64.
- freeListError_o  out  1  sticky error flag.

Behaviour:
- State:
  - list[0..63] of 6-bit indices.
  - head and tail pointers, 6 bits each, wrapping mod 64.
  - count, 7 bits.
  - error, 1 bit.
- Reset (async, reset_n=0):
  - list[i]=i; head=0; tail=0; count=64; error=0.
  - Resulting outputs: allocEntry0..3_o=0,1,2,3; freeCount_o=64; allocGrant_o=0; iqStall_o=0; freeListError_o=0.
  - Reset asserted mid-operation discards all in-flight state immediately.
- Read path (combinational):
  - allocEntryk_o = list[(head+k) mod 64].
  - Values are don't-care for k >= count.
- Grant (combinational):
  - grant = dispatchReady_i & ~ctrlMispredict_i & (count >= dispatchCount_i).
  - allocGrant_o = grant.
  - iqStall_o = dispatchReady_i & ~ctrlMispredict_i & (count < dispatchCount_i).
  - Granting is all-or-nothing: no partial allocation.
  - A dispatchCount_i of 0 with dispatchReady_i=1 is granted and consumes nothing.
- Allocation (registered):
  - On grant, head <= head + dispatchCount_i (mod 64) at the next edge.
  - Granted entries are consumed by dispatch in that same cycle. Latency from request to grant is 0.
- Freeing (registered):
  - Valid freed ports are compacted in port order 0→3 and written to list[tail], list[tail+1], …
  - tail <= tail + popcount(freedValid).
  - Invalid ports write nothing. Any valid pattern is legal, e.g. only ports 1 and 3 valid.
  - Entries freed in cycle N are visible on allocEntry outputs from cycle N+1. No same-cycle bypass.
- Count:
  - count_next = count − (grant ? dispatchCount_i : 0) + popcount(freedValid).
  - The grant check uses the current registered count only. Same-cycle frees do not help a request.
- Simultaneous allocate and free:
  - Both apply in the same edge.
  - Read and write regions cannot overlap while count_next <= 64.
- Wrap-around: pointer arithmetic is modulo 64; writes and reads span the 63→0 boundary seamlessly.
- Full: count=64 with any freed valid means overflow. error is set sticky until reset, the write is dropped, and count saturates at 64.
- Empty: count=0 with dispatchCount_i >= 1 stalls. The list state is unchanged apart from frees.
- Illegal dispatchCount_i > 4: treated as a stall and sets error.
- Mispredict: allocGrant_o=0 and iqStall_o=0 for that cycle. Frees still proceed.

Test Plan:
- Reset release: allocEntry0..3_o=0,1,2,3; freeCount_o=64; error=0.
- Drain: dispatchCount_i=4 granted for 16 consecutive cycles → allocEntry sequence 0..63, then freeCount_o=0. Next dispatchCount_i=1 → iqStall_o=1, allocGrant_o=0.
- Sparse free at empty: freedValid1=1 (entry 5) and freedValid3=1 (entry 9) → next cycle freeCount_o=2, allocEntry0_o=5, allocEntry1_o=9. dispatchCount_i=2 then granted, freeCount_o becomes 0.
- Concurrent traffic at count=4 with head=62: allocate 4 and free 4 (entries 10,11,12,13) in the same cycle → grant=1, head=2, freeCount_o=4, allocEntry0..3_o=10,11,12,13. This checks wrap-around.
- Mispredict with dispatchReady_i=1, dispatchCount_i=2, count=20, one free → allocGrant_o=0, iqStall_o=0, freeCount_o=21.
- Overflow at count=64 with freedValid0=1 → freeListError_o=1 and stays 1. Asserting reset_n=0 mid-run then restores the reset state.
